// File: rtl/std_acc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : std_acc_pipe
// Purpose  : Unsigned accumulator with a go/done handshake. It sits after the
//            pipelined multiplier so a controller can chain the two into a
//            multi-cycle MAC. It keeps a widened running sum, a saturating
//            accumulation count and a sticky overflow flag.
// Options  : `define STD_ACC_SATURATE_EN to clamp out to all ones when the
//            sum overflows. Without it, out wraps modulo 2^ACC_WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module std_acc_pipe #(
   parameter int WIDTH     = 32,
   parameter int ACC_WIDTH = 40,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,     // asynchronous, active low
   input  logic                 go,
   input  logic                 clear,
   input  logic [WIDTH-1:0]     in,
   output logic [ACC_WIDTH-1:0] out,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 overflow,
   output logic                 done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       op_q, op_d;
   logic                   clr_q, clr_d;
   logic [ACC_WIDTH-1:0]   out_q, out_d;
   logic [CNT_WIDTH-1:0]   count_q, count_d;
   logic                   overflow_q, overflow_d;
   logic                   done_q, done_d;

   logic [ACC_WIDTH:0]     w_op_ext;
   logic [ACC_WIDTH:0]     w_base;
   logic [ACC_WIDTH:0]     w_sum;

   // Widened sum: the extra top bit is the carry that flags overflow.
   always_comb begin
      w_op_ext              = '0;
      w_op_ext[WIDTH-1:0]   = op_q;
      w_base                = clr_q ? '0 : {1'b0, out_q};
      w_sum                 = w_op_ext + w_base;
   end

   // Next-state logic: capture in IDLE/DONE, commit in ADD, abort on go low.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      clr_d      = clr_q;
      out_d      = out_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (go) begin
               op_d    = in;
               clr_d   = clear;
               state_d = S_ADD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ADD: begin
            if (go) begin
`ifdef STD_ACC_SATURATE_EN
               out_d = w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
               out_d = w_sum[ACC_WIDTH-1:0];
`endif
               if (clr_q) begin
                  count_d = C_CNT_ONE;
               end else if (count_q != C_CNT_MAX) begin
                  count_d = count_q + C_CNT_ONE;
               end
               overflow_d = (clr_q ? 1'b0 : overflow_q) | w_sum[ACC_WIDTH];
               done_d     = 1'b1;
               state_d    = S_DONE;
            end else begin
               // Abort: drop the captured operand, leave results untouched.
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers; reset discards any pending accumulation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         clr_q      <= 1'b0;
         out_q      <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         clr_q      <= clr_d;
         out_q      <= out_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   assign out      = out_q;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_std_acc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_std_acc_pipe
// Purpose  : Self-checking bench for std_acc_pipe (WIDTH=8, ACC_WIDTH=12,
//            CNT_WIDTH=4). Directed steps followed by random operations,
//            checked against an integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_std_acc_pipe;

   localparam int W  = 8;
   localparam int AW = 12;
   localparam int CW = 4;
   localparam int ACC_MAX = (1 << AW) - 1;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk;
   logic          rst_n;
   logic          go;
   logic          clear;
   logic [W-1:0]  in_v;
   logic [AW-1:0] out_v;
   logic [CW-1:0] count_v;
   logic          overflow_v;
   logic          done_v;

   int checks;
   int errors;

   // Reference state
   int m_acc;
   int m_cnt;
   int m_ovf;

   std_acc_pipe #(
      .WIDTH     (W),
      .ACC_WIDTH (AW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk      (clk),
      .reset    (rst_n),
      .go       (go),
      .clear    (clear),
      .in       (in_v),
      .out      (out_v),
      .count    (count_v),
      .overflow (overflow_v),
      .done     (done_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the accumulation rules.
   task automatic model_add(input bit clr, input int val);
      int s;
      s = val + (clr ? 0 : m_acc);
      m_cnt = clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
      m_ovf = (clr ? 0 : m_ovf) | ((s > ACC_MAX) ? 1 : 0);
`ifdef STD_ACC_SATURATE_EN
      m_acc = (s > ACC_MAX) ? ACC_MAX : s;
`else
      m_acc = s % (ACC_MAX + 1);
`endif
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_out"},   32'(out_v),      32'(m_acc));
      chk({tag, "_count"}, 32'(count_v),    32'(m_cnt));
      chk({tag, "_ovf"},   32'(overflow_v), 32'(m_ovf));
   endtask

   // One accumulation: capture edge then ADD edge; go is left high.
   // Called 1 time unit after a clock edge.
   task automatic do_op(input string tag, input bit clr, input logic [W-1:0] val);
      go    = 1'b1;
      clear = clr;
      in_v  = val;
      @(posedge clk); #1;
      chk({tag, "_done_low_capture"}, 32'(done_v), 32'd0);
      // Operand and clear must be ignored after the capture edge.
      in_v  = W'($urandom);
      clear = 1'($urandom);
      @(posedge clk); #1;
      model_add(clr, int'(val));
      chk({tag, "_done"}, 32'(done_v), 32'd1);
      chk_state(tag);
   endtask

   task automatic idle_cycle(input string tag);
      go    = 1'b0;
      clear = 1'($urandom);
      in_v  = W'($urandom);
      @(posedge clk); #1;
      chk({tag, "_done_idle"}, 32'(done_v), 32'd0);
      chk_state({tag, "_idle"});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_acc  = 0;
      m_cnt  = 0;
      m_ovf  = 0;
      rst_n  = 1'b0;
      go     = 1'b0;
      clear  = 1'b0;
      in_v   = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_done", 32'(done_v), 32'd0);
      chk_state("rst");
      rst_n = 1'b1;
      idle_cycle("post_rst");

      // First op with clear, then three back-to-back adds
      do_op("first", 1'b1, 8'h25);
      chk("first_out_const", 32'(out_v), 32'h025);
      do_op("b2b0", 1'b0, 8'hFF);
      chk("b2b0_out_const", 32'(out_v), 32'h124);
      do_op("b2b1", 1'b0, 8'h10);
      chk("b2b1_out_const", 32'(out_v), 32'h134);
      do_op("b2b2", 1'b0, 8'h80);
      chk("b2b2_out_const", 32'(out_v), 32'h1B4);
      idle_cycle("after_b2b");

      // Build 0xFF0 = 16 * 0xFF, then overflow it
      do_op("fill0", 1'b1, 8'hFF);
      for (int i = 1; i < 16; i++) do_op("fill", 1'b0, 8'hFF);
      chk("fill_out_const", 32'(out_v), 32'hFF0);
      do_op("wrap", 1'b0, 8'h20);
`ifdef STD_ACC_SATURATE_EN
      chk("wrap_out_const", 32'(out_v), 32'hFFF);
`else
      chk("wrap_out_const", 32'(out_v), 32'h010);
`endif
      chk("wrap_ovf_const", 32'(overflow_v), 32'd1);
      do_op("sticky", 1'b0, 8'h01);
      do_op("reclear", 1'b1, 8'h01);
      chk("reclear_out_const", 32'(out_v), 32'h001);
      chk("reclear_ovf_const", 32'(overflow_v), 32'd0);

      // Count saturation: 17 accumulations in total since the clear
      for (int i = 0; i < 16; i++) do_op("sat", 1'b0, 8'h01);
      chk("sat_count_const", 32'(count_v), 32'd15);
      chk("sat_out_const", 32'(out_v), 32'h011);
      idle_cycle("after_sat");

      // Abort: go only for the capture edge
      go    = 1'b1;
      clear = 1'b1;
      in_v  = 8'h77;
      @(posedge clk); #1;
      go = 1'b0;
      @(posedge clk); #1;
      chk("abort_done", 32'(done_v), 32'd0);
      chk_state("abort");
      idle_cycle("abort2");
      do_op("post_abort", 1'b0, 8'h03);
      idle_cycle("post_abort");

      // Random operations with random gaps and clears
      for (int i = 0; i < 80; i++) begin
         do_op("rnd", ($urandom_range(0, 7) == 0), W'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            int gap;
            gap = $urandom_range(1, 2);
            for (int g = 0; g < gap; g++) idle_cycle("rnd_gap");
         end
      end

      // Asynchronous reset in the middle of an ADD
      go    = 1'b1;
      clear = 1'b0;
      in_v  = 8'h5A;
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      m_acc = 0;
      m_cnt = 0;
      m_ovf = 0;
      chk("arst_done", 32'(done_v), 32'd0);
      chk_state("arst");
      go = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_cycle("arst_release");
      do_op("after_arst", 1'b0, 8'h05);
      chk("after_arst_out_const", 32'(out_v), 32'h005);
      idle_cycle("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
